vc_wrr_scheduler: RTL and testbench

Scheduler that shares one output path between the two virtual-channel FIFOs, VC0 and VC1.
It pops at most one word per cycle from whichever VC holds the grant, using weighted round-robin.
It steers each popped word to output FIFO D0 or D1 according to a destination bit, and honours almost-full backpressure from both output FIFOs.
It sits between the VC FIFOs and the D0/D1 demux FIFOs, and replaces ad-hoc priority between the VCs.

---
 rtl/vc_wrr_scheduler_if.sv | 44 ++++
 rtl/vc_wrr_scheduler.sv | 113 +++++++++++
 tb/tb_vc_wrr_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vc_wrr_scheduler_if.sv
// Bundle of the VC FIFO heads, the D0/D1 push side, weights and FSM state
// shared between the weighted round-robin scheduler and its surroundings.
interface vc_wrr_scheduler_if #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 4
);
    // VC0 FIFO (first-word-fall-through head)
    logic [DATA_WIDTH-1:0] vc0_data;
    logic                  vc0_empty;
    logic                  vc0_pop;
    // VC1 FIFO (first-word-fall-through head)
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  vc1_empty;
    logic                  vc1_pop;
    // Per-VC turn lengths
    logic [CNT_WIDTH-1:0]  weight_vc0;
    logic [CNT_WIDTH-1:0]  weight_vc1;
    // Destination FIFOs
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  d0_push;
    logic                  d1_push;
    // Scheduler FSM state
    logic [1:0]            state;

    // Scheduler side: consumes VC heads, produces pops and pushes
    modport master (
        input  vc0_data, vc0_empty, vc1_data, vc1_empty,
        input  weight_vc0, weight_vc1,
        input  d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop,
        output data_out, d0_push, d1_push, state
    );

    // Environment side: presents VC heads, receives pops and pushes
    modport slave (
        output vc0_data, vc0_empty, vc1_data, vc1_empty,
        output weight_vc0, weight_vc1,
        output d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop,
        input  data_out, d0_push, d1_push, state
    );
endinterface

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin scheduler between two VC FIFOs. Pops at most one head
// word per cycle, steers it to D0 or D1 by its destination bit, and skips any
// head whose destination FIFO is almost full.
module vc_wrr_scheduler #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    vc_wrr_scheduler_if.master  bus
);
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SERVE0 = 2'b01;
    localparam logic [1:0] ST_SERVE1 = 2'b10;

    // Turn bookkeeping: owner 0 = VC0, 1 = VC1
    logic                  owner_q, owner_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            state_q, state_d;
    // Output register stage
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  d0_push_q, d0_push_d;
    logic                  d1_push_q, d1_push_d;

    logic                  e0, e1;
    logic                  e_owner, e_other;
    logic [CNT_WIDTH-1:0]  w0, w1, w_owner, w_other;
    logic                  grant_valid;
    logic                  grant_vc;
    logic [DATA_WIDTH-1:0] popped;
    logic                  pop0, pop1;

    // A head is eligible when present and its own destination can take it
    always_comb begin
        e0 = !bus.vc0_empty &&
             !(bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
        e1 = !bus.vc1_empty &&
             !(bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
        w0 = (bus.weight_vc0 == '0) ? CNT_WIDTH'(1) : bus.weight_vc0;
        w1 = (bus.weight_vc1 == '0) ? CNT_WIDTH'(1) : bus.weight_vc1;
    end

    // Grant selection: continue turn, else switch, else restart own turn
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        e_owner     = owner_q ? e1 : e0;
        e_other     = owner_q ? e0 : e1;
        w_owner     = owner_q ? w1 : w0;
        w_other     = owner_q ? w0 : w1;
        grant_valid = 1'b0;
        grant_vc    = owner_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        if (e_owner && cnt_q != '0) begin
            grant_valid = 1'b1;
            cnt_d       = cnt_q - CNT_WIDTH'(1);
        end else if (e_other) begin
            grant_valid = 1'b1;
            grant_vc    = !owner_q;
            owner_d     = !owner_q;
            cnt_d       = w_other - CNT_WIDTH'(1);
        end else if (e_owner) begin
            grant_valid = 1'b1;
            cnt_d       = w_owner - CNT_WIDTH'(1);
        end
    end

    // Pops, next FSM state and next output-stage contents from the grant
    always_comb begin
        // Pops are suppressed during reset so a word is never lost to it
        pop0       = grant_valid && !grant_vc && !reset;
        pop1       = grant_valid &&  grant_vc && !reset;
        popped     = grant_vc ? bus.vc1_data : bus.vc0_data;
        state_d    = ST_IDLE;
        data_out_d = data_out_q;
        d0_push_d  = 1'b0;
        d1_push_d  = 1'b0;
        if (grant_valid) begin
            state_d    = grant_vc ? ST_SERVE1 : ST_SERVE0;
            data_out_d = popped;
            d0_push_d  = !popped[DEST_BIT];
            d1_push_d  =  popped[DEST_BIT];
        end
    end

    // State and output registers; owner resets to VC1 so VC0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            data_out_q <= '0;
            d0_push_q  <= 1'b0;
            d1_push_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            data_out_q <= data_out_d;
            d0_push_q  <= d0_push_d;
            d1_push_q  <= d1_push_d;
        end
    end

    assign bus.vc0_pop  = pop0;
    assign bus.vc1_pop  = pop1;
    assign bus.data_out = data_out_q;
    assign bus.d0_push  = d0_push_q;
    assign bus.d1_push  = d1_push_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Directed bench for vc_wrr_scheduler: a table of per-cycle inputs with
// hand-computed pops and registered outputs, plus reset sequences.
module tb_vc_wrr_scheduler;
    localparam int DW = 6;
    localparam int DB = 4;
    localparam int CW = 4;

    localparam logic [DW-1:0] WA = 6'b100101; // dest bit 0 -> D0
    localparam logic [DW-1:0] WB = 6'b110110; // dest bit 1 -> D1
    localparam logic [DW-1:0] WC = 6'b110100; // dest bit 1 -> D1

    typedef struct {
        logic          v0e;
        logic [DW-1:0] v0d;
        logic          v1e;
        logic [DW-1:0] v1d;
        logic [CW-1:0] w0;
        logic [CW-1:0] w1;
        logic          d0af;
        logic          d1af;
        logic          x_pop0;
        logic          x_pop1;
        logic [1:0]    x_state;
        logic          x_d0p;
        logic          x_d1p;
        logic [DW-1:0] x_data;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vq[$];

    vc_wrr_scheduler_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus_if ();

    vc_wrr_scheduler #(.DATA_WIDTH(DW), .DEST_BIT(DB), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0e, input logic [DW-1:0] v0d,
                         input logic v1e, input logic [DW-1:0] v1d,
                         input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                         input logic d0af, input logic d1af);
        bus_if.vc0_empty      = v0e;
        bus_if.vc0_data       = v0d;
        bus_if.vc1_empty      = v1e;
        bus_if.vc1_data       = v1d;
        bus_if.weight_vc0     = w0;
        bus_if.weight_vc1     = w1;
        bus_if.d0_almost_full = d0af;
        bus_if.d1_almost_full = d1af;
    endtask

    task automatic add(input logic v0e, input logic [DW-1:0] v0d,
                       input logic v1e, input logic [DW-1:0] v1d,
                       input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                       input logic d0af, input logic d1af,
                       input logic p0, input logic p1, input logic [1:0] st,
                       input logic d0p, input logic d1p, input logic [DW-1:0] dat);
        vq.push_back('{v0e, v0d, v1e, v1d, w0, w1, d0af, d1af, p0, p1, st, d0p, d1p, dat});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, WA, 1'b0, WB, 4'd1, 4'd1, 1'b0, 1'b0);

        // Alternation, weights 1/1 (owner starts as VC1 so VC0 goes first)
        for (int i = 0; i < 2; i++) begin
            add(0, WA, 0, WB, 1, 1, 0, 0, 1, 0, 2'b01, 1, 0, WA);
            add(0, WA, 0, WB, 1, 1, 0, 0, 0, 1, 2'b10, 0, 1, WB);
        end
        // Weighted turns 3/1: pattern 0,0,0,1,0,0,0,1
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++)
                add(0, WA, 0, WB, 3, 1, 0, 0, 1, 0, 2'b01, 1, 0, WA);
            add(0, WA, 0, WB, 3, 1, 0, 0, 0, 1, 2'b10, 0, 1, WB);
        end
        // Weight 0 on VC1 acts as 1
        for (int i = 0; i < 2; i++) begin
            add(0, WA, 0, WB, 1, 0, 0, 0, 1, 0, 2'b01, 1, 0, WA);
            add(0, WA, 0, WB, 1, 0, 0, 0, 0, 1, 2'b10, 0, 1, WB);
        end
        // Head blocking: VC0 head bound for D1 while D1 almost full
        add(0, WC, 0, WA, 1, 1, 0, 1, 0, 1, 2'b10, 1, 0, WA);
        add(0, WC, 0, WA, 1, 1, 0, 1, 0, 1, 2'b10, 1, 0, WA);
        add(0, WC, 0, WA, 1, 1, 0, 0, 1, 0, 2'b01, 0, 1, WC);
        add(0, WC, 0, WA, 1, 1, 0, 0, 0, 1, 2'b10, 1, 0, WA);
        // Empty mid-turn, weights 4/4: VC0 holds 2 words
        add(0, WA, 0, WB, 4, 4, 0, 0, 1, 0, 2'b01, 1, 0, WA);
        add(0, WA, 0, WB, 4, 4, 0, 0, 1, 0, 2'b01, 1, 0, WA);
        add(1, WA, 0, WB, 4, 4, 0, 0, 0, 1, 2'b10, 0, 1, WB);
        // Both empty: idle, data_out holds
        add(1, WA, 1, WB, 4, 4, 0, 0, 0, 0, 2'b00, 0, 0, WB);
        // Both destinations almost full: both ineligible
        add(0, WA, 0, WB, 4, 4, 1, 1, 0, 0, 2'b00, 0, 0, WB);
        // Resume: VC1 keeps its preserved credit instead of yielding to VC0
        add(0, WA, 0, WB, 4, 4, 0, 0, 0, 1, 2'b10, 0, 1, WB);

        // Reset held two cycles with both VCs non-empty
        #1 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_pop0",  bus_if.vc0_pop,  0);
            check("rst_pop1",  bus_if.vc1_pop,  0);
            check("rst_state", bus_if.state,    0);
            check("rst_data",  bus_if.data_out, 0);
            check("rst_d0p",   bus_if.d0_push,  0);
            check("rst_d1p",   bus_if.d1_push,  0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Table: drive, check pops, clock, check registered outputs
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].v0e, vq[i].v0d, vq[i].v1e, vq[i].v1d,
                  vq[i].w0, vq[i].w1, vq[i].d0af, vq[i].d1af);
            #1;
            check($sformatf("v%0d_pop0", i), bus_if.vc0_pop, vq[i].x_pop0);
            check($sformatf("v%0d_pop1", i), bus_if.vc1_pop, vq[i].x_pop1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_state", i), bus_if.state,    vq[i].x_state);
            check($sformatf("v%0d_d0p", i),   bus_if.d0_push,  vq[i].x_d0p);
            check($sformatf("v%0d_d1p", i),   bus_if.d1_push,  vq[i].x_d1p);
            check($sformatf("v%0d_data", i),  bus_if.data_out, vq[i].x_data);
            @(negedge clk);
        end

        // Reset mid-turn: VC1 owns with two credits left
        drive(1'b0, WA, 1'b0, WB, 4'd4, 4'd4, 1'b0, 1'b0);
        #1;
        check("mid_pop1_before", bus_if.vc1_pop, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_pop0_rst",  bus_if.vc0_pop,  0);
        check("mid_pop1_rst",  bus_if.vc1_pop,  0);
        check("mid_state_rst", bus_if.state,    0);
        check("mid_data_rst",  bus_if.data_out, 0);
        @(posedge clk);
        #1;
        check("mid_d0p_edge", bus_if.d0_push, 0);
        check("mid_d1p_edge", bus_if.d1_push, 0);
        check("mid_state_edge", bus_if.state, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_pop0", bus_if.vc0_pop, 1);
        check("rel_pop1", bus_if.vc1_pop, 0);
        @(posedge clk);
        #1;
        check("rel_state", bus_if.state,    2'b01);
        check("rel_data",  bus_if.data_out, WA);
        check("rel_d0p",   bus_if.d0_push,  1);
        check("rel_d1p",   bus_if.d1_push,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
